// File: rtl/extram_fifo_bridge.sv
// CPU external-register-window bridge: 32-bit TX FIFO drained as 16-bit halfwords on a valid/ready stream.
// Optional 16-bit RX FIFO back to the CPU is enabled by defining EXTRAM_FIFO_RX_EN.
module extram_fifo_bridge #(
  parameter int DEPTH_LOG2    = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_a,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        bus_cs,
  input  logic        bus_oe,
  input  logic [3:0]  bus_wstrb,
  output logic [15:0] strm_data,
  output logic        strm_valid,
  input  logic        strm_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] TX_FULL_LVL = 8'(DEPTH);

  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_RXDATA  = 2'd3
  } reg_e;

  reg_e reg_sel;
  logic rd_acc, wr_acc, flush, clr_err;
  assign reg_sel = reg_e'(bus_a[3:2]);
  assign rd_acc  = bus_cs & bus_oe;
  assign wr_acc  = bus_cs & (|bus_wstrb);
  assign flush   = wr_acc & (reg_sel == REG_CONTROL) & bus_wdata[0];
  assign clr_err = wr_acc & (reg_sel == REG_CONTROL) & bus_wdata[1];

  logic unused_bits;
  assign unused_bits = ^{bus_a[15:4], bus_a[1:0]};

  logic [31:0]           tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [7:0]            tx_level_q, tx_level_d;
  logic [31:0]           out_word_q, out_word_d;
  logic                  phase_q, phase_d, valid_q, valid_d;
  logic                  ovf_q, ovf_d, werr_q, werr_d, unf_q, unf_d, irq_en_q, irq_en_d;
  logic                  mem_we, tx_wr, push_req, push_ok, word_done, need_load, fifo_empty;
  logic                  tx_empty, tx_full;

  logic [7:0]  rx_level_s;
  logic        rx_empty_s, rx_ovf_set, rx_unf_set;
  logic [15:0] rx_head_s;

  assign tx_empty = (tx_level_q == 8'd0);
  assign tx_full  = (tx_level_q == TX_FULL_LVL);

  // The output stage counts toward the level, so the FIFO proper is empty when level equals valid.
  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    out_word_d = out_word_q;
    phase_d    = phase_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    werr_d     = werr_q;
    unf_d      = unf_q;
    irq_en_d   = irq_en_q;
    mem_we     = 1'b0;

    tx_wr      = wr_acc & (reg_sel == REG_TXDATA);
    push_req   = tx_wr & (bus_wstrb == 4'hF);
    word_done  = valid_q & strm_ready & phase_q;
    need_load  = ~valid_q | word_done;
    fifo_empty = (tx_level_q == {7'd0, valid_q});
    push_ok    = push_req & (~tx_full | word_done);

    if (valid_q && strm_ready && !phase_q)
      phase_d = 1'b1;

    if (need_load) begin
      phase_d = 1'b0;
      if (!fifo_empty) begin
        out_word_d = tx_mem[tx_rptr_q];
        tx_rptr_d  = tx_rptr_q + DEPTH_LOG2'(1);
        valid_d    = 1'b1;
      end else if (push_ok) begin
        out_word_d = bus_wdata;
        valid_d    = 1'b1;
      end else begin
        valid_d    = 1'b0;
      end
    end

    if (push_ok && !(need_load && fifo_empty)) begin
      mem_we    = 1'b1;
      tx_wptr_d = tx_wptr_q + DEPTH_LOG2'(1);
    end

    tx_level_d = tx_level_q + 8'(push_ok) - 8'(word_done);

    if (clr_err) begin
      ovf_d  = 1'b0;
      werr_d = 1'b0;
      unf_d  = 1'b0;
    end
    if (tx_wr && !push_req)
      werr_d = 1'b1;
    if ((push_req && !push_ok) || rx_ovf_set)
      ovf_d = 1'b1;
    if (rx_unf_set)
      unf_d = 1'b1;

    if (wr_acc && reg_sel == REG_CONTROL)
      irq_en_d = bus_wdata[2];

    if (flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_level_d = 8'd0;
      out_word_d = 32'd0;
      phase_d    = 1'b0;
      valid_d    = 1'b0;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      tx_mem[tx_wptr_q] <= bus_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= 8'd0;
      out_word_q <= 32'd0;
      phase_q    <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      werr_q     <= 1'b0;
      unf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_level_q <= tx_level_d;
      out_word_q <= out_word_d;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      werr_q     <= werr_d;
      unf_q      <= unf_d;
      irq_en_q   <= irq_en_d;
    end
  end

`ifdef EXTRAM_FIFO_RX_EN
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [7:0] RX_FULL_LVL = 8'(RX_DEPTH);

  logic [15:0]              rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [7:0]               rx_level_q, rx_level_d;
  logic                     rx_rd, rx_pop, rx_push;

  // A CPU read of RXDATA pops the head in the same cycle, freeing a slot for a concurrent push.
  always_comb begin
    rx_rd      = rd_acc & (reg_sel == REG_RXDATA);
    rx_pop     = rx_rd & (rx_level_q != 8'd0);
    rx_push    = rx_valid & ((rx_level_q != RX_FULL_LVL) | rx_pop);
    rx_ovf_set = rx_valid & ~rx_push;
    rx_unf_set = rx_rd & ~rx_pop;
    rx_wptr_d  = rx_push ? rx_wptr_q + RX_DEPTH_LOG2'(1) : rx_wptr_q;
    rx_rptr_d  = rx_pop ? rx_rptr_q + RX_DEPTH_LOG2'(1) : rx_rptr_q;
    rx_level_d = rx_level_q + 8'(rx_push) - 8'(rx_pop);
    if (flush) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_level_d = 8'd0;
    end
    rx_level_s = rx_level_q;
    rx_empty_s = (rx_level_q == 8'd0);
    rx_head_s  = rx_empty_s ? 16'd0 : rx_mem[rx_rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rx_push && !flush)
      rx_mem[rx_wptr_q] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= 8'd0;
    end else begin
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
    end
  end
`else
  assign rx_level_s = 8'd0;
  assign rx_empty_s = 1'b1;
  assign rx_head_s  = 16'd0;
  assign rx_ovf_set = 1'b0;
  assign rx_unf_set = 1'b0;

  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid, rd_acc, (RX_DEPTH_LOG2 > 0)};
`endif

  always_comb begin
    bus_rdata = 32'd0;
    case (reg_sel)
      REG_STATUS:  bus_rdata = {6'd0, unf_q, rx_empty_s, rx_level_s, 4'd0,
                                werr_q, ovf_q, tx_full, tx_empty, tx_level_q};
      REG_CONTROL: bus_rdata = {29'd0, irq_en_q, 2'b00};
      REG_RXDATA:  bus_rdata = {16'd0, rx_head_s};
      default:     bus_rdata = 32'd0;
    endcase
  end

  assign strm_data  = phase_q ? out_word_q[31:16] : out_word_q[15:0];
  assign strm_valid = valid_q;
  assign irq        = irq_en_q & tx_empty;

endmodule

// File: tb/tb_extram_fifo_bridge.sv
// Scoreboard bench for extram_fifo_bridge: expected halfwords queued at push time, checked on each stream handshake.
// RX checks follow EXTRAM_FIFO_RX_EN the same way the design does.
module tb_extram_fifo_bridge;

  localparam logic [15:0] A_TXDATA  = 16'h0000;
  localparam logic [15:0] A_STATUS  = 16'h0004;
  localparam logic [15:0] A_CONTROL = 16'h0008;
  localparam logic [15:0] A_RXDATA  = 16'h000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_a = 16'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_cs = 1'b0;
  logic        bus_oe = 1'b0;
  logic [3:0]  bus_wstrb = 4'd0;
  logic [15:0] strm_data;
  logic        strm_valid;
  logic        strm_ready = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic        rx_valid = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  extram_fifo_bridge dut (
    .clk(clk), .rst(rst),
    .bus_a(bus_a), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_cs(bus_cs), .bus_oe(bus_oe), .bus_wstrb(bus_wstrb),
    .strm_data(strm_data), .strm_valid(strm_valid), .strm_ready(strm_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  // Every accepted halfword must match the head of the scoreboard; extra output is a fault.
  always @(negedge clk) begin
    if (!rst && strm_valid && strm_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL stream_unexpected got %h required no data", strm_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (strm_data !== e) begin
          n_fail++;
          $display("[TB] FAIL stream_data got %h required %h", strm_data, e);
        end
      end
    end
  end

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge clk); #1;
    bus_cs = 1'b1; bus_a = addr; bus_wdata = data; bus_wstrb = strb;
    @(posedge clk); #1;
    bus_cs = 1'b0; bus_wstrb = 4'd0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    bus_cs = 1'b1; bus_oe = 1'b1; bus_a = addr;
    @(negedge clk);
    data = bus_rdata;
    @(posedge clk); #1;
    bus_cs = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input bit accepted);
    if (accepted) begin
      exp_q.push_back(w[15:0]);
      exp_q.push_back(w[31:16]);
    end
    bus_write(A_TXDATA, w, 4'hF);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout remaining %0d required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (strm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b required 0", strm_valid); end
    n_checks++;
    if (strm_data !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_data got %h required 0000", strm_data); end
    rst = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got %b required 0", irq); end
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL reset_status got %h required 01000100", r); end
  endtask

  task automatic test_single_word();
    logic [31:0] r;
    strm_ready = 1'b1;
    push_word(32'hA5A5_1234, 1'b1);
    n_checks++;
    if (strm_valid !== 1'b1 || strm_data !== 16'h1234) begin
      n_fail++;
      $display("[TB] FAIL single_latency got valid=%b data=%h required valid=1 data=1234", strm_valid, strm_data);
    end
    wait_drain();
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL single_status got %h required 01000100", r); end
    strm_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    strm_ready = 1'b0;
    for (int i = 0; i < 17; i++)
      push_word({8'hC0, 8'(i), 8'hD0, 8'(i)}, i < 16);
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0610) begin n_fail++; $display("[TB] FAIL ovf_status got %h required 01000610", r); end
    strm_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (strm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_drained_valid got %b required 0", strm_valid); end
    bus_write(A_CONTROL, 32'h2, 4'hF);
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL ovf_clear got %h required 01000100", r); end
    strm_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] r;
    strm_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      push_word({8'h3C, 8'(i), 8'h4D, 8'(i)}, 1'b1);
    // The next push lands on the same edge the head word finishes its high half.
    strm_ready = 1'b1;
    push_word(32'hFEED_F00D, 1'b1);
    wait_drain();
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL fullpp_status got %h required 01000100", r); end
    strm_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    int first = -1;
    int last = -1;
    strm_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          push_word({16'h7000 + 16'(i), 16'h8000 + 16'(i)}, 1'b1);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          if (strm_valid) begin
            cnt++;
            if (first < 0) first = c;
            last = c;
          end
        end
      end
    join
    n_checks++;
    if (cnt != 8 || (last - first + 1) != 8) begin
      n_fail++;
      $display("[TB] FAIL b2b_bubble got count=%0d span=%0d required 8 and 8", cnt, last - first + 1);
    end
    wait_drain();
    strm_ready = 1'b0;
  endtask

  task automatic test_partial_strobe();
    logic [31:0] r;
    bus_write(A_TXDATA, 32'hDEAD_BEEF, 4'b0011);
    n_checks++;
    if (strm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL werr_valid got %b required 0", strm_valid); end
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0900) begin n_fail++; $display("[TB] FAIL werr_status got %h required 01000900", r); end
    bus_write(A_CONTROL, 32'h2, 4'hF);
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL werr_clear got %h required 01000100", r); end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    strm_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_word(32'h1111_0000 + 32'(i), 1'b1);
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0000_0003 + 32'h0100_0000) begin n_fail++; $display("[TB] FAIL flush_pre_status got %h required 01000003", r); end
    bus_write(A_CONTROL, 32'h4, 4'hF);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_irq_busy got %b required 0", irq); end
    exp_q.delete();
    bus_write(A_CONTROL, 32'h5, 4'hF);
    n_checks++;
    if (strm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got %b required 0", strm_valid); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_irq got %b required 1", irq); end
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL flush_status got %h required 01000100", r); end
    bus_read(A_CONTROL, r);
    n_checks++;
    if (r !== 32'h0000_0004) begin n_fail++; $display("[TB] FAIL flush_control got %h required 00000004", r); end
    bus_write(A_CONTROL, 32'h0, 4'hF);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_disable got %b required 0", irq); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] r;
    strm_ready = 1'b0;
    push_word(32'h2222_3333, 1'b0);
    push_word(32'h4444_5555, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (strm_valid !== 1'b0 || strm_data !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL midreset_out got valid=%b data=%h required 0 0000", strm_valid, strm_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL midreset_status got %h required 01000100", r); end
  endtask

  task automatic rx_offer(input logic [15:0] d);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

`ifdef EXTRAM_FIFO_RX_EN
  task automatic test_rx();
    logic [31:0] r;
    logic [31:0] rx_exp[$];
    rx_exp.push_back(32'h0000_BEEF);
    rx_exp.push_back(32'h0000_0042);
    rx_exp.push_back(32'h0000_0000);
    rx_offer(16'hBEEF);
    rx_offer(16'h0042);
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0002_0100) begin n_fail++; $display("[TB] FAIL rx_status got %h required 00020100", r); end
    while (rx_exp.size() != 0) begin
      logic [31:0] e;
      e = rx_exp.pop_front();
      bus_read(A_RXDATA, r);
      n_checks++;
      if (r !== e) begin n_fail++; $display("[TB] FAIL rx_data got %h required %h", r, e); end
    end
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0300_0100) begin n_fail++; $display("[TB] FAIL rx_unf got %h required 03000100", r); end
    bus_write(A_CONTROL, 32'h2, 4'hF);
  endtask
`else
  task automatic test_rx();
    logic [31:0] r;
    rx_offer(16'hBEEF);
    bus_read(A_RXDATA, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL rx_off_data got %h required 00000000", r); end
    bus_read(A_STATUS, r);
    n_checks++;
    if (r !== 32'h0100_0100) begin n_fail++; $display("[TB] FAIL rx_off_status got %h required 01000100", r); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_partial_strobe();
    test_flush();
    test_rx();
    test_reset_mid_transfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
